// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Stateful ID-stage stall controller. Tracks pending GPR
//                writes in a per-register countdown scoreboard, the busy time
//                of the multiply/divide unit and one outstanding CP0 write.
//                Combines them with the decoded ID instruction into a single
//                stall, a per-cause vector and a saturating stall counter.
//
//  Ports       :
//    clk            in   rising-edge clock
//    rst_n          in   asynchronous active-low reset
//    id_valid       in   ID holds a valid instruction
//    id_rs_used     in   rs operand is read
//    id_rs_addr     in   rs register address
//    id_rs_tuse     in   cycles after ID until rs is consumed
//    id_rt_used     in   rt operand is read
//    id_rt_addr     in   rt register address
//    id_rt_tuse     in   cycles after ID until rt is consumed
//    id_wr_en       in   instruction writes a GPR
//    id_wr_addr     in   destination register
//    id_wr_tnew     in   cycles after leaving ID until result is forwardable
//    id_mdu_use     in   any MDU instruction
//    id_mdu_start   in   instruction starts a mult/div
//    id_mdu_is_div  in   the start is a divide
//    id_mtc0        in   mtc0
//    id_mfc0        in   mfc0
//    id_eret        in   eret
//    id_cp0_addr    in   CP0 register index for mtc0/mfc0
//    flush          in   squash all younger in-flight instructions
//    stall          out  freeze PC/IF/ID, bubble EX
//    stall_cause    out  [0] rs data, [1] rt data, [2] MDU, [3] CP0
//    mdu_busy       out  MDU busy counter is nonzero
//    stall_count    out  saturating count of stalled cycles
//
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int TNEW_W    = 2,
    parameter int MDU_CNT_W = 4,
    parameter int MUL_LAT   = 5,
    parameter int DIV_LAT   = 10,
    parameter int CP0_LAT   = 2,
    parameter int EPC_ADDR  = 14,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic                 id_rs_used,
    input  logic [ADDR_W-1:0]    id_rs_addr,
    input  logic [TNEW_W-1:0]    id_rs_tuse,
    input  logic                 id_rt_used,
    input  logic [ADDR_W-1:0]    id_rt_addr,
    input  logic [TNEW_W-1:0]    id_rt_tuse,
    input  logic                 id_wr_en,
    input  logic [ADDR_W-1:0]    id_wr_addr,
    input  logic [TNEW_W-1:0]    id_wr_tnew,
    input  logic                 id_mdu_use,
    input  logic                 id_mdu_start,
    input  logic                 id_mdu_is_div,
    input  logic                 id_mtc0,
    input  logic                 id_mfc0,
    input  logic                 id_eret,
    input  logic [4:0]           id_cp0_addr,
    input  logic                 flush,
    output logic                 stall,
    output logic [3:0]           stall_cause,
    output logic                 mdu_busy,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int CP0_CNT_W = (CP0_LAT < 1) ? 1 : $clog2(CP0_LAT + 1);

    localparam logic [MDU_CNT_W-1:0] c_mul_lat  = MDU_CNT_W'(MUL_LAT);
    localparam logic [MDU_CNT_W-1:0] c_div_lat  = MDU_CNT_W'(DIV_LAT);
    localparam logic [CP0_CNT_W-1:0] c_cp0_lat  = CP0_CNT_W'(CP0_LAT);
    localparam logic [4:0]           c_epc_addr = 5'(EPC_ADDR);

    // Remaining cycles until each register's pending result is forwardable.
    // Entry 0 exists only to keep indexing simple; it is never loaded.
    logic [TNEW_W-1:0]    r_sb [NUM_REGS];
    logic [MDU_CNT_W-1:0] r_mdu_cnt;
    logic                 r_cp0_pend;
    logic [4:0]           r_cp0_addr;
    logic [CP0_CNT_W-1:0] r_cp0_cnt;
    logic [CNT_W-1:0]     r_stall_count;

    logic [TNEW_W-1:0]    w_rs_tnew;
    logic [TNEW_W-1:0]    w_rt_tnew;
    logic                 w_rs_hazard;
    logic                 w_rt_hazard;
    logic                 w_mdu_hazard;
    logic                 w_cp0_hazard;
    logic                 w_mdu_busy;
    logic [3:0]           w_cause;
    logic                 w_stall;
    logic                 w_accept;

    // ------------------------------------------------------------------
    // Scoreboard lookup. Addresses of register 0 or beyond NUM_REGS read
    // as "ready" so they can never raise a data hazard.
    // ------------------------------------------------------------------
    always_comb begin
        w_rs_tnew = '0;
        w_rt_tnew = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (int'(id_rs_addr) == i) w_rs_tnew = r_sb[i];
            if (int'(id_rt_addr) == i) w_rt_tnew = r_sb[i];
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        w_mdu_busy   = (r_mdu_cnt != '0);
        w_rs_hazard  = id_valid && id_rs_used && (id_rs_addr != '0) &&
                       (w_rs_tnew > id_rs_tuse);
        w_rt_hazard  = id_valid && id_rt_used && (id_rt_addr != '0) &&
                       (w_rt_tnew > id_rt_tuse);
        w_mdu_hazard = id_valid && id_mdu_use && w_mdu_busy;
        // A second mtc0 waits for the first so the tracker only ever needs
        // to hold one outstanding write.
        w_cp0_hazard = id_valid && r_cp0_pend &&
                       ((id_eret && (r_cp0_addr == c_epc_addr)) ||
                        (id_mfc0 && (r_cp0_addr == id_cp0_addr)) ||
                        id_mtc0);
        w_cause      = {w_cp0_hazard, w_mdu_hazard, w_rt_hazard, w_rs_hazard};
        w_stall      = |w_cause;
        w_accept     = id_valid && !w_stall && !flush;
    end

    // ------------------------------------------------------------------
    // Scoreboard update: flush clears, otherwise a load from the accepted
    // instruction wins over the per-cycle countdown.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_sb[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) r_sb[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_accept && id_wr_en && (int'(id_wr_addr) == i)) begin
                    r_sb[i] <= id_wr_tnew;
                end else if (r_sb[i] != '0) begin
                    r_sb[i] <= r_sb[i] - TNEW_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // MDU busy counter. Flush leaves it alone: the issued operation keeps
    // running in the unit regardless of what is squashed in the pipe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdu_cnt <= '0;
        end else if (w_accept && id_mdu_start) begin
            r_mdu_cnt <= id_mdu_is_div ? c_div_lat : c_mul_lat;
        end else if (w_mdu_busy) begin
            r_mdu_cnt <= r_mdu_cnt - MDU_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // CP0 write tracker
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cp0_pend <= 1'b0;
            r_cp0_addr <= '0;
            r_cp0_cnt  <= '0;
        end else if (flush) begin
            r_cp0_pend <= 1'b0;
            r_cp0_addr <= '0;
            r_cp0_cnt  <= '0;
        end else if (w_accept && id_mtc0) begin
            r_cp0_pend <= 1'b1;
            r_cp0_addr <= id_cp0_addr;
            r_cp0_cnt  <= c_cp0_lat;
        end else if (r_cp0_pend) begin
            if (r_cp0_cnt > CP0_CNT_W'(1)) begin
                r_cp0_cnt <= r_cp0_cnt - CP0_CNT_W'(1);
            end else begin
                r_cp0_cnt  <= '0;
                r_cp0_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall performance counter (saturating, reset-only clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (id_valid && w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall       = w_stall;
    assign stall_cause = w_cause;
    assign mdu_busy    = w_mdu_busy;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, stateful replacement for the pipeline stall controller.
- Holds a per-register countdown scoreboard of pending writes, a multiply/divide unit (MDU) busy counter and a CP0 write tracker.
- Combines these with the decoded ID-stage instruction to produce one stall signal, a stall-cause vector and a stall-cycle performance counter.
- Sits beside the ID stage; its `stall` output freezes PC/IF/ID and injects a bubble into EX.

Parameters:
- NUM_REGS, 32: architectural GPR count; register 0 is never tracked.
- ADDR_W, 5: register address width; NUM_REGS <= 2**ADDR_W.
- TNEW_W, 2: width of Tnew/Tuse fields and of each scoreboard entry.
- MDU_CNT_W, 4: width of the MDU busy counter.
- MUL_LAT, 5: busy cycles loaded on a multiply start.
- DIV_LAT, 10: busy cycles loaded on a divide start; must be < 2**MDU_CNT_W.
- CP0_LAT, 2: cycles until an accepted mtc0 is visible to mfc0/eret.
- EPC_ADDR, 14: CP0 register index that eret reads.
- CNT_W, 32: stall performance counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs_used, id_rt_used  in  1  operand is read.
- id_rs_addr, id_rt_addr  in  ADDR_W  source register.
- id_rs_tuse, id_rt_tuse  in  TNEW_W  cycles after ID until the operand is consumed (0 = consumed in ID).
- id_wr_en  in  1  instruction writes a GPR.
- id_wr_addr  in  ADDR_W  destination register.
- id_wr_tnew  in  TNEW_W  cycles after leaving ID until the result is forwardable.
- id_mdu_use  in  1  any MDU instruction (mult/div/mfhi/mflo/mthi/mtlo).
- id_mdu_start  in  1  instruction starts a mult/div.
- id_mdu_is_div  in  1  the start is a divide.
- id_mtc0, id_mfc0, id_eret  in  1  CP0 instruction class.
- id_cp0_addr  in  5  CP0 register index for mtc0/mfc0.
- flush  in  1  squash all younger in-flight instructions.
- stall  out  1  freeze ID, bubble EX.
- stall_cause  out  4  [0] rs data, [1] rt data, [2] MDU, [3] CP0.
- mdu_busy  out  1  MDU counter nonzero.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, rst_n=0): all scoreboard entries, MDU counter, CP0 pending flag/counter and stall_count go to 0. The outputs stall, stall_cause and mdu_busy are therefore 0.
- Stall is combinational from current state and ID inputs. All causes are gated by id_valid.
- rs hazard: id_rs_used && id_rs_addr!=0 && sb[id_rs_addr] > id_rs_tuse. The rt hazard is identical using the rt fields.
- MDU hazard: id_mdu_use && mdu_busy.
- CP0 hazard: requires cp0_pend, and any one of:
  - id_eret && pend_addr==EPC_ADDR;
  - id_mfc0 && pend_addr==id_cp0_addr;
  - id_mtc0 (a second mtc0 is serialised behind a pending one).
- stall = OR of stall_cause.
- Accept = id_valid && !stall && !flush.
- Scoreboard update, each clk edge:
  - Every nonzero entry decrements by 1 (saturates at 0).
  - On accept with id_wr_en && id_wr_addr!=0, that entry loads id_wr_tnew instead; the load wins over the decrement.
  - A stalled instruction loads nothing (it is a bubble).
- MDU counter:
  - Decrements to 0.
  - On accept with id_mdu_start, it loads DIV_LAT if id_mdu_is_div, else MUL_LAT.
  - A start is only accepted when the counter is 0.
- CP0 tracker:
  - On accept with id_mtc0: cp0_pend=1, pend_addr=id_cp0_addr, counter=CP0_LAT.
  - Otherwise, while pending, the counter decrements; when it reaches 1→0, cp0_pend clears.
- flush:
  - Clears all scoreboard entries and the CP0 tracker in the same edge, with priority over decrement and load.
  - Does NOT clear the MDU counter, because the operation already issued continues.
  - No load occurs in a flush cycle.
- stall_count increments on every edge where id_valid && stall. It saturates at all-ones and is never cleared except by reset.
- Zero-latency results (tnew=0) never create hazards. Register 0 is never written or stalled on.
- Reset mid-operation: all state is lost and no stall is asserted after reset deasserts.

Test Plan:
- Load-use: a lw accepted with wr_addr=8, tnew=2; next cycle a beq with rs=8, tuse=0 → stall=1 for 2 cycles with cause=4'b0001, then 0. stall_count=2.
- ALU→store data: an add with rd=9, tnew=1; next an sw with rt=9, tuse=2 → no stall. A branch with rt=9, tuse=0 in the same slot → 1 stall cycle, cause=4'b0010.
- Register 0: a write with wr_addr=0, tnew=3, then a read of reg 0 with tuse=0 → no stall, and all scoreboard entries stay 0.
- MDU: a div is accepted; mfhi follows → stall for DIV_LAT=10 cycles with cause=4'b0100 and mdu_busy high. A mult issued afterwards reloads the counter to 5.
- CP0: mtc0 addr 14 accepted, then eret → stall for CP0_LAT=2 cycles with cause=4'b1000. An mfc0 of addr 12 instead → no stall.
- Flush: a lw with tnew=2 is accepted; flush=1 next cycle with a dependent branch in ID → stall drops the following cycle. An in-progress div keeps mdu_busy=1. Then rst_n=0 mid-div → all outputs 0 immediately.
